// File: rtl/dadda_seq.sv
// Purpose : per-phrase sequencer for the blitter data-adder A mux (DATA, Z1, Z2 steps).
// Latency : first select 1 cycle after start; each step takes ADD_LAT+2 cycles; done 1 cycle after the last load.
// Backpres: level-sensitive stall freezes SEL/WAIT/LATCH with no pulses; abort returns to IDLE silently.
//
// Ports:
//   sys_clk, reset                    - clock; synchronous active-high reset
//   start                             - phrase start, accepted only in IDLE
//   gourd, srcadd, data_en, gourz,
//   zwide                             - step-list mode bits, captured at accepted start
//   stall, abort                      - sequence freeze / cancel
//   daddasel                          - registered adder A select
//   add_go, data_ld, z1_ld, z2_ld     - adder strobe and result-latch load pulses
//   busy, done                        - not-IDLE flag, one-cycle completion pulse
module dadda_seq #(
    parameter int ADD_LAT = 1
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       gourd,
    input  logic       srcadd,
    input  logic       data_en,
    input  logic       gourz,
    input  logic       zwide,
    input  logic       stall,
    input  logic       abort,
    output logic [2:0] daddasel,
    output logic       add_go,
    output logic       data_ld,
    output logic       z1_ld,
    output logic       z2_ld,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(ADD_LAT - 1);

    state_t     state, state_nxt;
    // pend: remaining steps, bit0 DATA, bit1 Z1, bit2 Z2; the lowest set bit is the current step.
    logic [2:0] pend, pend_nxt;
    logic [2:0] data_sel, data_sel_nxt;
    logic [1:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] daddasel_nxt;

    logic [2:0] cur_oh;
    logic [2:0] pend_left;
    logic [2:0] start_mask;
    logic [2:0] start_dsel;
    logic       pulse_ok;

    function automatic logic [2:0] sel_for(input logic [2:0] mask, input logic [2:0] dcode);
        logic [2:0] s;
        if (mask[0])      s = dcode;
        else if (mask[1]) s = 3'b100;
        else              s = 3'b101;
        return s;
    endfunction

    assign cur_oh     = pend & (~pend + 3'd1);
    assign pend_left  = pend & ~cur_oh;
    assign start_mask = {gourz & zwide, gourz, data_en};
    assign start_dsel = gourd ? 3'b010 : (srcadd ? 3'b001 : 3'b000);

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        data_sel_nxt = data_sel;
        wait_cnt_nxt = wait_cnt;
        daddasel_nxt = daddasel;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pend_nxt     = start_mask;
                    data_sel_nxt = start_dsel;
                    if (start_mask != 3'b000) begin
                        state_nxt    = S_SEL;
                        daddasel_nxt = sel_for(start_mask, start_dsel);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_SEL: begin
                if (!stall) begin
                    wait_cnt_nxt = LAT_M1;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!stall) begin
                    if (wait_cnt == 2'd0) state_nxt = S_LATCH;
                    else                  wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            S_LATCH: begin
                if (!stall) begin
                    pend_nxt = pend_left;
                    if (pend_left != 3'b000) begin
                        state_nxt    = S_SEL;
                        daddasel_nxt = sel_for(pend_left, data_sel);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort cancels from any active state; select and step bookkeeping hold.
        if (abort && (state != S_IDLE)) begin
            state_nxt    = S_IDLE;
            pend_nxt     = pend;
            data_sel_nxt = data_sel;
            wait_cnt_nxt = wait_cnt;
            daddasel_nxt = daddasel;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pend     <= 3'b000;
            data_sel <= 3'b000;
            wait_cnt <= 2'd0;
            daddasel <= 3'b000;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            data_sel <= data_sel_nxt;
            wait_cnt <= wait_cnt_nxt;
            daddasel <= daddasel_nxt;
        end
    end

    // Pulses are state decodes; a reset cycle also suppresses them so nothing leaks out.
    assign pulse_ok = !stall && !abort && !reset;
    assign add_go   = (state == S_SEL)   && pulse_ok;
    assign data_ld  = (state == S_LATCH) && cur_oh[0] && pulse_ok;
    assign z1_ld    = (state == S_LATCH) && cur_oh[1] && pulse_ok;
    assign z2_ld    = (state == S_LATCH) && cur_oh[2] && pulse_ok;
    assign done     = (state == S_DONE)  && !abort && !reset;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_dadda_seq.sv
// Purpose : randomized scoreboard bench for dadda_seq with a transaction-level timeline model.
// Latency : model predicts every pulse cycle plus per-cycle busy/daddasel from the stall schedule.
// Backpres: stall schedule is fixed up front so the model can walk it when a start is issued.
module tb_dadda_seq;

    localparam int LAT  = 3;
    localparam int NCYC = 2000;
    localparam int NA   = NCYC + 200;

    logic       sys_clk = 1'b0;
    logic       reset, start, gourd, srcadd, data_en, gourz, zwide, stall, abort;
    logic [2:0] daddasel;
    logic       add_go, data_ld, z1_ld, z2_ld, busy, done;

    always #5 sys_clk = ~sys_clk;

    dadda_seq #(.ADD_LAT(LAT)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .start   (start),
        .gourd   (gourd),
        .srcadd  (srcadd),
        .data_en (data_en),
        .gourz   (gourz),
        .zwide   (zwide),
        .stall   (stall),
        .abort   (abort),
        .daddasel(daddasel),
        .add_go  (add_go),
        .data_ld (data_ld),
        .z1_ld   (z1_ld),
        .z2_ld   (z2_ld),
        .busy    (busy),
        .done    (done)
    );

    // Pulse kinds as one-hot {done, z2_ld, z1_ld, data_ld, add_go}.
    localparam logic [4:0] K_GO   = 5'b00001;
    localparam logic [4:0] K_DATA = 5'b00010;
    localparam logic [4:0] K_Z1   = 5'b00100;
    localparam logic [4:0] K_Z2   = 5'b01000;
    localparam logic [4:0] K_DONE = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] kind;
    } ev_t;

    ev_t        evq[$];
    bit         exp_busy[NA];
    logic [2:0] exp_sel[NA];
    bit         stall_at[NA];
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_pass = 0;
    bit         mon_en = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endfunction

    function void mark(input int t, input logic [2:0] s);
        if (t < NA) begin
            exp_busy[t] = 1'b1;
            exp_sel[t]  = s;
        end
    endfunction

    function void push_ev(input int t, input logic [4:0] k);
        ev_t e;
        e.cyc  = t;
        e.kind = k;
        evq.push_back(e);
    endfunction

    // Walks the enabled step list over the stall schedule and records the expected timeline.
    task automatic model_start(input int c0, input bit g, input bit sa, input bit de,
                               input bit gz, input bit zw);
        logic [4:0] kq[$];
        logic [2:0] sq[$];
        int         t;
        int         n;
        logic [2:0] cur;
        if (de) begin kq.push_back(K_DATA); sq.push_back(g ? 3'b010 : (sa ? 3'b001 : 3'b000)); end
        if (gz) begin kq.push_back(K_Z1); sq.push_back(3'b100); end
        if (gz && zw) begin kq.push_back(K_Z2); sq.push_back(3'b101); end
        t   = c0 + 1;
        cur = exp_sel[c0];
        foreach (kq[i]) begin
            cur = sq[i];
            while (t < NA && stall_at[t]) begin mark(t, cur); t++; end
            push_ev(t, K_GO); mark(t, cur); t++;
            n = 0;
            while (n < LAT && t < NA) begin
                mark(t, cur);
                if (!stall_at[t]) n++;
                t++;
            end
            while (t < NA && stall_at[t]) begin mark(t, cur); t++; end
            push_ev(t, kq[i]); mark(t, cur); t++;
        end
        push_ev(t, K_DONE); mark(t, cur);
        for (int k = t + 1; k < NA; k++) begin
            exp_busy[k] = 1'b0;
            exp_sel[k]  = cur;
        end
    endtask

    // Abort or reset at cycle c: no pulses from c on, idle afterwards.
    function void cancel(input int c, input bit is_reset);
        logic [2:0] hold;
        hold = is_reset ? 3'b000 : exp_sel[c];
        while (evq.size() > 0 && evq[$].cyc >= c) void'(evq.pop_back());
        for (int k = c + 1; k < NA; k++) begin
            exp_busy[k] = 1'b0;
            exp_sel[k]  = hold;
        end
    endfunction

    always @(negedge sys_clk) begin
        logic [4:0] p;
        if (mon_en) begin
            p = {done, z2_ld, z1_ld, data_ld, add_go};
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("event_missed", 32'(5'b00000), 32'(evq[0].kind));
                void'(evq.pop_front());
            end
            chk("pulse_onehot", 32'($countones(p) <= 1), 32'(1));
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                chk("pulse", 32'(p), 32'(evq[0].kind));
                void'(evq.pop_front());
            end else begin
                chk("no_pulse", 32'(p), 32'(0));
            end
            chk("busy", 32'(busy), 32'(exp_busy[cyc]));
            chk("daddasel", 32'(daddasel), 32'(exp_sel[cyc]));
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        gourd = 1'b0; srcadd = 1'b0; data_en = 1'b0; gourz = 1'b0; zwide = 1'b0;
        for (int i = 0; i < NA; i++) begin
            exp_busy[i] = 1'b0;
            exp_sel[i]  = 3'b000;
            stall_at[i] = (i >= 80) && (i < NCYC - 100) && ($urandom_range(0, 3) == 0);
        end
        stall_at[35] = 1'b1;
        stall_at[36] = 1'b1;

        for (int c = 1; c < NCYC; c++) begin
            @(posedge sys_clk);
            #1;
            cyc    = c;
            mon_en = 1'b1;
            reset  = 1'b0;
            start  = 1'b0;
            abort  = 1'b0;
            stall  = stall_at[c];
            {gourd, srcadd, data_en, gourz, zwide} = 5'($urandom);
            case (c)
                3:  begin start = 1'b1; data_en = 1'b1; srcadd = 1'b1; gourd = 1'b0; gourz = 1'b0; end
                5:  start = 1'b1;
                12: begin start = 1'b1; data_en = 1'b1; gourd = 1'b1; gourz = 1'b1; zwide = 1'b1; end
                30: begin start = 1'b1; data_en = 1'b0; gourz = 1'b0; end
                33: begin start = 1'b1; data_en = 1'b0; gourz = 1'b1; zwide = 1'b0; end
                45: begin start = 1'b1; data_en = 1'b1; gourz = 1'b1; zwide = 1'b0; end
                53: abort = 1'b1;
                60: begin start = 1'b1; data_en = 1'b1; gourz = 1'b1; zwide = 1'b1; end
                65: reset = 1'b1;
                default: begin
                    if (c >= 80 && c < NCYC - 100) begin
                        if ($urandom_range(0, 199) == 0) reset = 1'b1;
                        else if (exp_busy[c] && $urandom_range(0, 39) == 0) abort = 1'b1;
                        if (!reset) start = ($urandom_range(0, 2) == 0);
                    end
                end
            endcase
            if (reset) begin
                cancel(c, 1'b1);
            end else begin
                if (abort && exp_busy[c]) cancel(c, 1'b0);
                if (start && !exp_busy[c]) model_start(c, gourd, srcadd, data_en, gourz, zwide);
            end
        end

        for (int c = NCYC; c < NCYC + 10; c++) begin
            @(posedge sys_clk);
            #1;
            cyc   = c;
            start = 1'b0;
            abort = 1'b0;
            stall = 1'b0;
        end
        @(posedge sys_clk);
        #1;
        mon_en = 1'b0;
        chk("events_left", 32'(evq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dadda_seq.md
# dadda_seq

Per-phrase sequencer for the blitter data-adder input mux. On each phrase start it walks an ordered list of adder operations (data, Z-low, Z-high) and drives the 3-bit `daddasel` select. For each operation it strobes the adder, waits a fixed settle time and pulses the matching result-latch load. It sits between the blitter inner-loop state machine (start/done/stall) and the data-path adder A mux, and is the only driver of `daddasel`.

## Interface
Parameters:
- `ADD_LAT`, 1: adder settle cycles between select and result capture; legal 1..4.

Ports:
- `sys_clk`  in  1  system clock; one clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  phrase start pulse; accepted only in IDLE.
- `gourd`  in  1  Gouraud data mode; sampled at accepted start.
- `srcadd`  in  1  add source rather than destination; sampled at accepted start.
- `data_en`  in  1  perform data step; sampled at accepted start.
- `gourz`  in  1  perform Z step 1; sampled at accepted start.
- `zwide`  in  1  also perform Z step 2; ignored unless `gourz`; sampled at accepted start.
- `stall`  in  1  freezes the sequence; level-sensitive.
- `abort`  in  1  cancels the current sequence.
- `daddasel`  out  3  adder A select.
- `add_go`  out  1  adder operand-load strobe.
- `data_ld`  out  1  data result latch load.
- `z1_ld`  out  1  Z1 result latch load.
- `z2_ld`  out  1  Z2 result latch load.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- `daddasel` encoding: 3'b000 dstd, 3'b001 srcd, 3'b010 patd, 3'b100 srcz1, 3'b101 srcz2. Other codes are never driven.
- Step list is captured at the accepted start, in this order. Disabled steps are skipped.
  - DATA, if `data_en`: select patd if `gourd`; else srcd if `srcadd`; else dstd. Load is `data_ld`.
  - Z1, if `gourz`: select srcz1. Load is `z1_ld`.
  - Z2, if `gourz & zwide`: select srcz2. Load is `z2_ld`.
- States:
  - IDLE: on `start`, capture the mode bits and go to SEL for the first enabled step. If no step is enabled, go to DONE.
  - SEL: drive the step's `daddasel`. Assert `add_go` if `!stall`. If `!stall`, load the wait counter with ADD_LAT-1 and go to WAIT.
  - WAIT: hold `daddasel`. While `!stall`, decrement the counter. Leave for LATCH in the cycle the counter is 0 and `!stall`, so WAIT lasts exactly ADD_LAT unstalled cycles.
  - LATCH: assert the step's load pulse if `!stall`. If `!stall`, go to SEL of the next enabled step, or to DONE.
  - DONE: `done`=1 for one cycle, then IDLE. `stall` has no effect in DONE.
- `daddasel` holds its last value in IDLE and DONE. It changes only on entry to SEL.
- `start` while `busy` is ignored. Mode-input changes mid-sequence are ignored.
- `abort` has priority over everything except `reset`. Asserted in any non-IDLE state, the next state is IDLE.
  - No `done` is issued.
  - No load pulse is issued in the abort cycle.
  - `daddasel` holds.
- `add_go`, `data_ld`, `z1_ld`, `z2_ld` and `done` are mutually exclusive and at most one cycle wide per event.

## Timing
- Reset values: state IDLE, `daddasel`=000, and `add_go`, `data_ld`, `z1_ld`, `z2_ld`, `busy`, `done` all 0. The wait counter is 0.
- Take the start cycle as cycle 0, N as the number of enabled steps, and no stall.
  - Step k (k=0..N-1): SEL at cycle 1+k(ADD_LAT+2), LATCH at SEL+ADD_LAT+1.
  - `done` at cycle 1+N(ADD_LAT+2).
  - For N=0, `done` at cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`. A new `start` is accepted in that cycle.
- Each stalled cycle in SEL, WAIT or LATCH adds exactly one cycle of latency. No pulses are emitted while stalled.
- Outputs are registered or decoded from registered state only. There is no combinational path from inputs to `daddasel` or `busy`. Pulses are state decodes ANDed with `!stall` and `!abort`.
- `reset` mid-sequence gives reset values on the next edge, with no pulses.

## Test plan
- Reset, then `start` with `data_en`=1, `srcadd`=1, ADD_LAT=1:
  - `daddasel`=001 from cycle 1.
  - `add_go` at cycle 1, `data_ld` at cycle 3, `done` at cycle 4.
  - `busy` high in cycles 1-4.
- `start` with `data_en`=1, `gourd`=1, `gourz`=1, `zwide`=1, ADD_LAT=1:
  - `daddasel` sequence 010 at cycles 1-3, 100 at cycles 4-6, 101 at cycles 7-9.
  - Loads `data_ld` at 3, `z1_ld` at 6, `z2_ld` at 9; `done` at 10.
- `start` with no steps enabled: `done` at cycle 1, no `add_go`, `daddasel` unchanged.
- ADD_LAT=3, Z1 only, `stall` high in cycles 2-3: `add_go` at cycle 1, `z1_ld` at cycle 7, `done` at cycle 8.
- Mid-sequence events:
  - `abort` at WAIT of step 2: IDLE next cycle, no `z1_ld`, no `done`.
  - A second `start` during `busy`: ignored.
  - `reset` during LATCH: all outputs 0 next cycle.
